// File: rtl/capture_fifo_bank_if.sv
// Signal bundle between the switch-fabric capture ports, the Avalon-MM host and capture_fifo_bank.
// The master side drives pushes, flushes and CSR reads; the slave side is the FIFO bank.
interface capture_fifo_bank_if #(
    parameter int NUM_CH = 3,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        push;
    logic [NUM_CH*DATA_W-1:0] push_data;
    logic [NUM_CH-1:0]        flush;
    logic                     chipselect;
    logic                     read;
    logic [5:0]               address;
    logic [DATA_W-1:0]        readdata;
    logic [NUM_CH-1:0]        full;
    logic [NUM_CH-1:0]        empty;
    logic [NUM_CH*8-1:0]      hex;

    modport master (
        output push, push_data, flush, chipselect, read, address,
        input  readdata, full, empty, hex
    );

    modport slave (
        input  push, push_data, flush, chipselect, read, address,
        output readdata, full, empty, hex
    );
endinterface

// File: rtl/capture_fifo_bank.sv
// Bank of NUM_CH capture FIFOs with a show-ahead head register and a registered-read CSR window.
// Optional feature macro HEX_DISPLAY_EN: per-channel seven-segment image of the last accepted word.
module capture_fifo_bank #(
    parameter int              NUM_CH     = 3,
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 12,
    parameter logic [DATA_W-1:0] EMPTY_WORD = DATA_W'(32'hFF),
    parameter logic [DATA_W-1:0] BAD_WORD   = DATA_W'(32'hFC),
    parameter logic [DATA_W-1:0] IDLE_WORD  = DATA_W'(32'hFB)
) (
    input  logic               clk,
    input  logic               reset_n,
    capture_fifo_bank_if.slave bus
);
    localparam int              DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W:0] LVL_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LVL_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0] LVL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef HEX_DISPLAY_EN
    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'h3F;  4'h1: s = 8'h06;  4'h2: s = 8'h5B;  4'h3: s = 8'h4F;
            4'h4: s = 8'h66;  4'h5: s = 8'h6D;  4'h6: s = 8'h7D;  4'h7: s = 8'h07;
            4'h8: s = 8'h7F;  4'h9: s = 8'h6F;  4'hA: s = 8'h77;  4'hB: s = 8'h7C;
            4'hC: s = 8'h39;  4'hD: s = 8'h5E;  4'hE: s = 8'h79;  4'hF: s = 8'h71;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    logic [7:0] w_hex_a [NUM_CH];
`endif

    logic [3:0] w_ch;
    logic [1:0] w_reg;
    logic       w_rd;

    assign w_ch  = bus.address[5:2];
    assign w_reg = bus.address[1:0];
    assign w_rd  = bus.chipselect && bus.read;

    // Per-channel views for the CSR mux; unused slots above NUM_CH read as zero.
    logic [DATA_W-1:0] w_popq_a  [16];
    logic [ADDR_W:0]   w_level_a [16];
    logic [15:0]       w_ovf_a   [16];
    logic [ADDR_W-1:0] w_wr_a    [16];
    logic [ADDR_W-1:0] w_rd_a    [16];

    for (genvar c = 0; c < 16; c++) begin : g_ch
        if (c < NUM_CH) begin : g_live
            logic [DATA_W-1:0] r_mem [DEPTH];
            logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
            logic [ADDR_W:0]   r_level;
            logic              r_hv;
            logic [DATA_W-1:0] r_head;
            logic [15:0]       r_ovf;
            logic [DATA_W-1:0] w_din, w_ram_q;
            logic [ADDR_W:0]   w_ram_cnt;
            logic              w_full, w_empty, w_pop, w_acc, w_ovf, w_take, w_load;

            assign w_din     = bus.push_data[c*DATA_W +: DATA_W];
            assign w_ram_q   = r_mem[r_rd_ptr];
            assign w_full    = (r_level == LVL_FULL);
            assign w_empty   = (r_level == LVL_ZERO);
            assign w_ram_cnt = r_level - {{ADDR_W{1'b0}}, r_hv};
            assign w_pop     = w_rd && (w_reg == 2'd0) && (w_ch == 4'(c)) && !w_empty;
            assign w_acc     = bus.push[c] && !w_full && !bus.flush[c];
            assign w_ovf     = bus.push[c] && w_full && !bus.flush[c];
            // The RAM word at rd_ptr leaves when the head is free or being popped; a pop
            // with an unfilled head takes it straight to readdata instead of the head.
            assign w_take    = (w_ram_cnt != LVL_ZERO) && (!r_hv || w_pop);
            assign w_load    = w_take && (r_hv || !w_pop);

            // Storage array write port
            always_ff @(posedge clk) begin
                if (w_acc) begin
                    r_mem[r_wr_ptr] <= w_din;
                end
            end

            // Pointers, level, head register and overflow counter
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wr_ptr <= {ADDR_W{1'b0}};
                    r_rd_ptr <= {ADDR_W{1'b0}};
                    r_level  <= LVL_ZERO;
                    r_hv     <= 1'b0;
                    r_head   <= {DATA_W{1'b0}};
                    r_ovf    <= 16'd0;
                end else if (bus.flush[c]) begin
                    r_wr_ptr <= {ADDR_W{1'b0}};
                    r_rd_ptr <= {ADDR_W{1'b0}};
                    r_level  <= LVL_ZERO;
                    r_hv     <= 1'b0;
                    r_ovf    <= 16'd0;
                end else begin
                    if (w_acc)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
                    if (w_take) r_rd_ptr <= r_rd_ptr + PTR_ONE;
                    if (w_load) r_head   <= w_ram_q;
                    r_hv <= w_load || (r_hv && !w_pop);
                    case ({w_acc, w_pop})
                        2'b10:   r_level <= r_level + LVL_ONE;
                        2'b01:   r_level <= r_level - LVL_ONE;
                        default: r_level <= r_level;
                    endcase
                    if (w_ovf && (r_ovf != 16'hFFFF)) r_ovf <= r_ovf + 16'd1;
                end
            end

`ifdef HEX_DISPLAY_EN
            logic [7:0] r_hex;

            // Seven-segment image of the last accepted word
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)          r_hex <= 8'h00;
                else if (bus.flush[c]) r_hex <= 8'h00;
                else if (w_acc)        r_hex <= seg7(w_din[3:0]);
                else                   r_hex <= r_hex;
            end
            assign w_hex_a[c] = r_hex;
`endif

            assign w_popq_a[c]  = r_hv ? r_head : w_ram_q;
            assign w_level_a[c] = r_level;
            assign w_ovf_a[c]   = r_ovf;
            assign w_wr_a[c]    = r_wr_ptr;
            assign w_rd_a[c]    = r_rd_ptr;
        end else begin : g_none
            assign w_popq_a[c]  = {DATA_W{1'b0}};
            assign w_level_a[c] = LVL_ZERO;
            assign w_ovf_a[c]   = 16'd0;
            assign w_wr_a[c]    = {ADDR_W{1'b0}};
            assign w_rd_a[c]    = {ADDR_W{1'b0}};
        end
    end

    logic [NUM_CH-1:0] w_full_v, w_empty_v;

    // Status flags straight from the channel levels
    always_comb begin
        w_full_v  = {NUM_CH{1'b0}};
        w_empty_v = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            w_full_v[c]  = (w_level_a[c] == LVL_FULL);
            w_empty_v[c] = (w_level_a[c] == LVL_ZERO);
        end
    end

    assign bus.full  = w_full_v;
    assign bus.empty = w_empty_v;

`ifdef HEX_DISPLAY_EN
    logic [NUM_CH*8-1:0] w_hex_v;

    // Flatten per-channel segment images onto the hex port
    always_comb begin
        w_hex_v = {(NUM_CH*8){1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            w_hex_v[c*8 +: 8] = w_hex_a[c];
        end
    end
    assign bus.hex = w_hex_v;
`else
    assign bus.hex = {(NUM_CH*8){1'b0}};
`endif

    logic [DATA_W-1:0] w_rd_mux;
    logic [DATA_W-1:0] r_readdata;

    // CSR read mux
    always_comb begin
        w_rd_mux = BAD_WORD;
        if (int'(w_ch) < NUM_CH) begin
            case (w_reg)
                2'd0:    w_rd_mux = (w_level_a[w_ch] == LVL_ZERO) ? EMPTY_WORD : w_popq_a[w_ch];
                2'd1:    w_rd_mux = DATA_W'({w_ovf_a[w_ch], 16'(w_level_a[w_ch])});
                2'd2:    w_rd_mux = DATA_W'(w_wr_a[w_ch]);
                2'd3:    w_rd_mux = DATA_W'(w_rd_a[w_ch]);
                default: w_rd_mux = BAD_WORD;
            endcase
        end else begin
            w_rd_mux = BAD_WORD;
        end
    end

    // Registered read data, idle pattern when no read is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  r_readdata <= IDLE_WORD;
        else if (w_rd) r_readdata <= w_rd_mux;
        else           r_readdata <= IDLE_WORD;
    end

    assign bus.readdata = r_readdata;
endmodule

// File: tb/tb_capture_fifo_bank.sv
// Scoreboard bench for capture_fifo_bank: stimulus queues expected readdata, a negedge monitor checks it.
module tb_capture_fifo_bank;
    localparam int NUM_CH = 3;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;
    localparam int DEPTH  = 4096;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    capture_fifo_bank_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus();

    capture_fifo_bank #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q [$];
    logic [31:0] mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        chk      = 1'b0;
    logic        chk_seen = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) chk_seen <= 1'b0;
        else          chk_seen <= chk;
    end

    // monitor: readdata registered on the edge after a checked cycle
    always @(negedge clk) begin
        if (chk_seen) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rdata_unexpected act=%h req=<none>", bus.readdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.readdata !== mon_e) begin
                    n_err++;
                    $display("FAIL rdata act=%h req=%h t=%0t", bus.readdata, mon_e, $time);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s act=%h req=%h", nm, act, req);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
        chk            = 1'b1;
        exp_q.push_back(e);
        cyc();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        chk            = 1'b0;
    endtask

    task automatic idle_chk(input logic [31:0] e);
        chk = 1'b1;
        exp_q.push_back(e);
        cyc();
        chk = 1'b0;
    endtask

    task automatic push_w(input int ch, input logic [31:0] d);
        bus.push[ch]               = 1'b1;
        bus.push_data[ch*32 +: 32] = d;
        cyc();
        bus.push[ch]               = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] e;
        bus.push       = 3'b000;
        bus.push_data  = {(NUM_CH*DATA_W){1'b0}};
        bus.flush      = 3'b000;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.address    = 6'h00;

        // reset state
        repeat (2) cyc();
        check("rst_empty", 32'(bus.empty), 32'h7);
        check("rst_full", 32'(bus.full), 32'h0);
        check("rst_rdata", bus.readdata, 32'hFB);
        check("rst_hex", 32'(bus.hex), 32'h0);
        reset_n = 1'b1;
        cyc();

        // empty channel registers, bad channel, idle
        rd(6'h00, 32'hFF);
        rd(6'h01, 32'h0);
        rd(6'h02, 32'h0);
        rd(6'h03, 32'h0);
        rd(6'h3C, 32'hFC);
        rd(6'h0D, 32'hFC);
        idle_chk(32'hFB);

        // ch1 three pushes then back-to-back pops
        push_w(1, 32'hA1);
        push_w(1, 32'hA2);
        push_w(1, 32'hA3);
        cyc();
        cyc();
        rd(6'h04, 32'hA1);
        rd(6'h04, 32'hA2);
        rd(6'h04, 32'hA3);
        rd(6'h04, 32'hFF);
        check("ch1_empty", 32'(bus.empty[1]), 32'h1);

        // fill ch0 and overflow by 5
        for (int i = 0; i < DEPTH; i++) push_w(0, 32'h1000_0000 + i);
        for (int i = 0; i < 5; i++) push_w(0, 32'hDEAD_0000 + i);
        check("ch0_full", 32'(bus.full[0]), 32'h1);
        check("ch0_not_empty", 32'(bus.empty[0]), 32'h0);
        rd(6'h01, 32'h0005_1000);
        for (int i = 0; i < DEPTH; i++) rd(6'h00, 32'h1000_0000 + i);
        rd(6'h00, 32'hFF);
        rd(6'h01, 32'h0005_0000);
        rd(6'h02, 32'h0);
        rd(6'h03, 32'h0);

        // pointer wrap: fill, drain 4000, push 4000 more
        for (int i = 0; i < DEPTH; i++) push_w(0, 32'h2000_0000 + i);
        for (int i = 0; i < 4000; i++) rd(6'h00, 32'h2000_0000 + i);
        for (int i = 0; i < 4000; i++) push_w(0, 32'h3000_0000 + i);
        check("wrap_full", 32'(bus.full[0]), 32'h1);
        rd(6'h02, 32'd4000);
        rd(6'h03, 32'd4001);
        rd(6'h01, 32'h0005_1000);
        for (int i = 0; i < 100; i++) begin
            e = (i < 96) ? (32'h2000_0000 + 32'd4000 + i) : (32'h3000_0000 + (i - 96));
            rd(6'h00, e);
        end

        // flush: clears ovf count, then flush at level 10 with concurrent push
        push_w(1, 32'hB1);
        push_w(1, 32'hB2);
        bus.flush[0] = 1'b1;
        cyc();
        bus.flush[0] = 1'b0;
        rd(6'h01, 32'h0);
        for (int i = 0; i < 10; i++) push_w(0, 32'h4000_0000 + i);
        rd(6'h01, 32'd10);
        bus.flush[0]           = 1'b1;
        bus.push[0]            = 1'b1;
        bus.push_data[31:0]    = 32'h77;
        cyc();
        bus.flush[0] = 1'b0;
        bus.push[0]  = 1'b0;
        rd(6'h01, 32'h0);
        rd(6'h02, 32'h0);
        rd(6'h03, 32'h0);
        rd(6'h00, 32'hFF);
        check("flush_empty", 32'(bus.empty[0]), 32'h1);
        rd(6'h05, 32'd2);
        rd(6'h04, 32'hB1);

        // ch2 same-cycle push and pop at level 7
        for (int i = 0; i < 7; i++) push_w(2, 32'hC0 + i);
        cyc();
        cyc();
        bus.push[2]          = 1'b1;
        bus.push_data[95:64] = 32'hC7;
        bus.chipselect       = 1'b1;
        bus.read             = 1'b1;
        bus.address          = 6'h08;
        chk                  = 1'b1;
        exp_q.push_back(32'hC0);
        cyc();
        bus.push[2]    = 1'b0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        chk            = 1'b0;
        rd(6'h09, 32'd7);
        for (int i = 1; i < 8; i++) rd(6'h08, 32'hC0 + i);
        rd(6'h08, 32'hFF);

        // hex image and asynchronous reset mid-stream
        push_w(2, 32'h2);
`ifdef HEX_DISPLAY_EN
        check("hex_push2", 32'(bus.hex[23:16]), 32'h5B);
`else
        check("hex_tied", 32'(bus.hex), 32'h0);
`endif
        push_w(2, 32'hE3);
        bus.push[2]          = 1'b1;
        bus.push_data[95:64] = 32'hE4;
        #2 reset_n = 1'b0;
        #1;
        check("arst_empty", 32'(bus.empty), 32'h7);
        check("arst_full", 32'(bus.full), 32'h0);
        check("arst_rdata", bus.readdata, 32'hFB);
        check("arst_hex", 32'(bus.hex), 32'h0);
        bus.push[2] = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        rd(6'h09, 32'h0);
        rd(6'h0A, 32'h0);
        rd(6'h0B, 32'h0);
        rd(6'h05, 32'h0);
        push_w(2, 32'h12);
`ifdef HEX_DISPLAY_EN
        check("hex_after_rst", 32'(bus.hex[23:16]), 32'h5B);
`else
        check("hex_after_rst", 32'(bus.hex), 32'h0);
`endif
        cyc();
        cyc();
        rd(6'h08, 32'h12);

        repeat (3) cyc();
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
